// File: rtl/depth_test_stage_pkg.sv
// depth_test_stage_pkg: viewport geometry, stream payload types, FSM states and depth quantizer.
// Depth is signed fixed point with FRAC_BITS fractional bits; 1.0 maps to the far plane.
package depth_test_stage_pkg;
    localparam int VIEWPORT_WIDTH  = 160;
    localparam int VIEWPORT_HEIGHT = 120;
    localparam int DEPTH_WIDTH     = 16;
    localparam int NUM_PIXELS      = VIEWPORT_WIDTH * VIEWPORT_HEIGHT;
    localparam int FB_ADDR_W       = $clog2(NUM_PIXELS);
    localparam int FRAC_BITS       = 24;

    typedef logic [FB_ADDR_W-1:0]   fb_address_t;
    typedef logic [DEPTH_WIDTH-1:0] depth_t;
    typedef logic [15:0]            color_t;
    typedef logic signed [31:0]     fixed_t;
    typedef logic [7:0]             coord_comp_t;

    typedef struct packed {
        coord_comp_t x;
        coord_comp_t y;
    } coordinate_t;

    typedef struct packed {
        coordinate_t coordinate;
        logic        valid;
        fixed_t      depth;
        color_t      color;
    } pixel_data_t;

    typedef struct packed {
        fb_address_t address;
        color_t      color;
    } fb_write_t;

    typedef enum logic [2:0] {CLEAR, IDLE, READ, COMPARE, OUTPUT} depth_test_state_t;

    localparam fixed_t FIXED_ONE = fixed_t'(1) <<< FRAC_BITS;

    // Behind the camera clamps to 0, at/after the far plane saturates to all ones.
    function automatic depth_t quantize_depth(fixed_t f);
        return f < 0 ? '0 : (f >= FIXED_ONE ? '1 : f[FRAC_BITS-1 -: DEPTH_WIDTH]);
    endfunction
endpackage

// File: rtl/depth_test_stage_if.sv
// depth_test_stage_if: sample input stream and framebuffer write output stream.
interface depth_test_stage_if;
    import depth_test_stage_pkg::*;
    logic        pixel_data_s_ready;
    logic        pixel_data_s_valid;
    pixel_data_t pixel_data_s_data;
    logic        fb_write_m_ready;
    logic        fb_write_m_valid;
    fb_write_t   fb_write_m_data;
    modport slave (
        input  pixel_data_s_valid, pixel_data_s_data, fb_write_m_ready,
        output pixel_data_s_ready, fb_write_m_valid, fb_write_m_data
    );
    modport master (
        output pixel_data_s_valid, pixel_data_s_data, fb_write_m_ready,
        input  pixel_data_s_ready, fb_write_m_valid, fb_write_m_data
    );
endinterface

// File: rtl/depth_test_stage_ram.sv
// depth_test_stage_ram: single-port depth buffer, synchronous read, no reset.
module depth_test_stage_ram
    import depth_test_stage_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  fb_address_t addr,
    input  depth_t      wdata,
    output depth_t      rdata
);
    depth_t mem [NUM_PIXELS];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/depth_test_stage.sv
// depth_test_stage: z-buffer test of sampler output, forwarding passing samples as framebuffer writes.
// Optional DEPTH_TEST_STATS_EN adds pass_count/fail_count outputs.
module depth_test_stage
    import depth_test_stage_pkg::*;
(
    depth_test_stage_if.slave bus,
    input  logic clk,
    input  logic rstn,
    input  logic clear_start,
    output logic clear_busy
`ifdef DEPTH_TEST_STATS_EN
    ,
    output logic [31:0] pass_count,
    output logic [31:0] fail_count
`endif
);
    depth_test_state_t state_q, state_d;
    fb_address_t clr_addr_q, clr_addr_d, addr_q, addr_d;
    fixed_t      depth_q, depth_d;
    color_t      color_q, color_d;
    fb_write_t   fb_data_q, fb_data_d;
    logic        pending_q, pending_d;
    depth_t      q, stored;
    logic        pass, in_range;

    assign q        = quantize_depth(depth_q);
    assign pass     = q < stored;
    assign in_range = bus.pixel_data_s_data.valid
                   && bus.pixel_data_s_data.coordinate.x < coord_comp_t'(VIEWPORT_WIDTH)
                   && bus.pixel_data_s_data.coordinate.y < coord_comp_t'(VIEWPORT_HEIGHT);

    depth_test_stage_ram u_ram (
        .clk   (clk),
        .we    (state_q == CLEAR || (state_q == COMPARE && pass)),
        .addr  (state_q == CLEAR ? clr_addr_q : addr_q),
        .wdata (state_q == CLEAR ? '1 : q),
        .rdata (stored)
    );

    // A pending clear holds off acceptance so the sample is never half-taken.
    assign bus.pixel_data_s_ready = state_q == IDLE && !pending_q && !clear_start;
    assign bus.fb_write_m_valid   = state_q == OUTPUT;
    assign bus.fb_write_m_data    = fb_data_q;
    assign clear_busy             = state_q == CLEAR;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        depth_d    = depth_q;
        color_d    = color_q;
        fb_data_d  = fb_data_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == fb_address_t'(NUM_PIXELS - 1)) begin
                    clr_addr_d = '0;
                    state_d    = IDLE;
                end
            end
            IDLE: begin
                if (pending_q || clear_start) begin
                    pending_d = 1'b0;
                    state_d   = CLEAR;
                end else if (bus.pixel_data_s_valid) begin
                    addr_d  = fb_address_t'(bus.pixel_data_s_data.coordinate.y) * fb_address_t'(VIEWPORT_WIDTH)
                            + fb_address_t'(bus.pixel_data_s_data.coordinate.x);
                    depth_d = bus.pixel_data_s_data.depth;
                    color_d = bus.pixel_data_s_data.color;
                    state_d = in_range ? READ : IDLE;
                end
            end
            READ:    state_d = COMPARE;
            COMPARE: begin
                state_d = pass ? OUTPUT : IDLE;
                if (pass) fb_data_d = '{address: addr_q, color: color_q};
            end
            OUTPUT:  state_d = bus.fb_write_m_ready ? IDLE : OUTPUT;
            default: state_d = CLEAR;
        endcase
        if (clear_start && !(state_q inside {CLEAR, IDLE})) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            pending_q  <= 1'b0;
            addr_q     <= '0;
            depth_q    <= '0;
            color_q    <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            depth_q    <= depth_d;
            color_q    <= color_d;
            fb_data_q  <= fb_data_d;
        end
    end

`ifdef DEPTH_TEST_STATS_EN
    logic [31:0] pass_q, fail_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pass_q <= '0;
            fail_q <= '0;
        end else if (state_d == CLEAR && state_q != CLEAR) begin
            pass_q <= '0;
            fail_q <= '0;
        end else if (state_q == COMPARE) begin
            pass_q <= pass_q + {31'b0, pass};
            fail_q <= fail_q + {31'b0, !pass};
        end
    end
    assign pass_count = pass_q;
    assign fail_count = fail_q;
`endif
endmodule

// File: tb/tb_depth_test_stage.sv
// tb_depth_test_stage: scoreboard bench for depth_test_stage (optionally with DEPTH_TEST_STATS_EN).
module tb_depth_test_stage;
    import depth_test_stage_pkg::*;

    logic clk = 1'b0;
    logic rstn, clear_start, clear_busy;
    int   n_cmp = 0, n_bad = 0;
    depth_t    mdl [NUM_PIXELS];
    fb_write_t exp_q [$];
    int        pass_n, fail_n;
`ifdef DEPTH_TEST_STATS_EN
    logic [31:0] pass_count, fail_count;
`endif

    depth_test_stage_if bus();

    depth_test_stage dut (
        .bus         (bus),
        .clk         (clk),
        .rstn        (rstn),
        .clear_start (clear_start),
        .clear_busy  (clear_busy)
`ifdef DEPTH_TEST_STATS_EN
        ,
        .pass_count  (pass_count),
        .fail_count  (fail_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic depth_t ref_quant(fixed_t d);
        if (d[31]) return 16'h0000;
        if (d[31:24] != 8'h00) return 16'hFFFF;
        return d[23:8];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_PIXELS; i++) mdl[i] = 16'hFFFF;
        pass_n = 0;
        fail_n = 0;
    endtask

    task automatic send(input int x, input int y, input logic v, input fixed_t d, input color_t c);
        pixel_data_t p;
        int n = 0;
        int a;
        depth_t qd;
        @(negedge clk);
        while (!bus.pixel_data_s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_ready_timeout", bus.pixel_data_s_ready, 1);
        p.coordinate.x = 8'(x);
        p.coordinate.y = 8'(y);
        p.valid = v;
        p.depth = d;
        p.color = c;
        bus.pixel_data_s_data  = p;
        bus.pixel_data_s_valid = 1'b1;
        if (v && x < VIEWPORT_WIDTH && y < VIEWPORT_HEIGHT) begin
            a  = y * VIEWPORT_WIDTH + x;
            qd = ref_quant(d);
            if (qd < mdl[a]) begin
                mdl[a] = qd;
                exp_q.push_back('{address: fb_address_t'(a), color: c});
                pass_n++;
            end else fail_n++;
        end
        @(posedge clk);
        #1 bus.pixel_data_s_valid = 1'b0;
    endtask

    task automatic count_clear(input bit pulse, output int n, output int bad);
        n = 0;
        bad = 0;
        while (clear_busy && n < 30000) begin
            if (bus.pixel_data_s_ready) bad++;
            clear_start = pulse && n == 100;
            n++;
            @(negedge clk);
        end
        clear_start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstn && bus.fb_write_m_valid && bus.fb_write_m_ready) begin
            if (exp_q.size() == 0) check("spurious_write", bus.fb_write_m_valid, 0);
            else check("fb_write", bus.fb_write_m_data, exp_q.pop_front());
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        fb_write_t w;
        rstn = 1'b0;
        clear_start = 1'b0;
        bus.pixel_data_s_valid = 1'b0;
        bus.pixel_data_s_data  = '0;
        bus.fb_write_m_ready   = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", clear_busy, 1);
        check("reset_s_ready", bus.pixel_data_s_ready, 0);
        check("reset_m_valid", bus.fb_write_m_valid, 0);
        check("reset_m_data", bus.fb_write_m_data, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        count_clear(0, n, bad);
        check("reset_clear_cycles", n, NUM_PIXELS);
        check("reset_clear_ready_low", bad, 0);
        check("ready_after_clear", bus.pixel_data_s_ready, 1);

        send(3, 2, 1, 32'sh0080_0000, 16'hF800);
        @(negedge clk) check("latency_c1", bus.fb_write_m_valid, 0);
        @(negedge clk) check("latency_c2", bus.fb_write_m_valid, 0);
        @(negedge clk) check("latency_c3", bus.fb_write_m_valid, 1);
        send(3, 2, 1, 32'sh00C0_0000, 16'h07E0);
        send(3, 2, 1, 32'sh0080_0000, 16'h001F);
        send(3, 2, 0, 32'sh0010_0000, 16'h1111);
        @(negedge clk) check("drop_invalid_ready", bus.pixel_data_s_ready, 1);
        send(VIEWPORT_WIDTH, 2, 1, 32'sh0010_0000, 16'h2222);
        @(negedge clk) check("drop_x_range_ready", bus.pixel_data_s_ready, 1);

        bus.fb_write_m_ready = 1'b0;
        send(10, 5, 1, 32'sh0040_0000, 16'hABCD);
        w = '{address: fb_address_t'(5 * VIEWPORT_WIDTH + 10), color: 16'hABCD};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus.fb_write_m_valid, 1);
            check("stall_data", bus.fb_write_m_data, w);
            check("stall_s_ready", bus.pixel_data_s_ready, 0);
            @(negedge clk);
        end
        bus.fb_write_m_ready = 1'b1;
        send(3, 2, 1, 32'sh00E6_6666, 16'h3333);
        repeat (4) @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
`ifdef DEPTH_TEST_STATS_EN
        check("pass_count", pass_count, 2);
        check("fail_count", fail_count, 3);
`endif

        send(3, 2, 1, 32'sh0040_0000, 16'h4444);
        @(negedge clk);
        @(negedge clk) clear_start = 1'b1;
        @(posedge clk);
        #1 clear_start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!clear_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("pending_clear_entered", clear_busy, 1);
        check("write_before_clear", exp_q.size(), 0);
`ifdef DEPTH_TEST_STATS_EN
        check("pass_count_cleared", pass_count, 0);
        check("fail_count_cleared", fail_count, 0);
`endif
        model_clear();
        count_clear(1, n, bad);
        check("pending_clear_cycles", n, NUM_PIXELS);
        check("pending_clear_ready_low", bad, 0);
        check("ready_after_pending_clear", bus.pixel_data_s_ready, 1);
        repeat (3) @(negedge clk);
        check("no_reclear", clear_busy, 0);

        send(3, 2, 1, 32'sh00C0_0000, 16'h5555);
        send(0, 0, 1, 32'shFFF0_0000, 16'h6666);
        send(0, 0, 1, 32'shFFF0_0000, 16'h7777);
        send(VIEWPORT_WIDTH - 1, VIEWPORT_HEIGHT - 1, 1, 32'sh0100_0000, 16'h8888);
        send(VIEWPORT_WIDTH - 1, VIEWPORT_HEIGHT - 1, 1, 32'sh0200_0000, 16'h9999);
        send(VIEWPORT_WIDTH - 1, VIEWPORT_HEIGHT - 1, 1, 32'sh00FF_FE00, 16'hAAAA);
        send(4, VIEWPORT_HEIGHT, 1, 32'sh0010_0000, 16'hBBBB);
        @(negedge clk) check("drop_y_range_ready", bus.pixel_data_s_ready, 1);
        repeat (10) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
`ifdef DEPTH_TEST_STATS_EN
        check("final_pass_count", pass_count, 32'(pass_n));
        check("final_fail_count", fail_count, 32'(fail_n));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
